// File: rtl/sysid_check_ctrl_if.sv
// ----------------------------------------------------------------------------
// sysid_check_ctrl_if
// Avalon-MM read-only bus between the sysid checker (master) and the sysid
// peripheral (slave).
//   avm_address       master -> slave  word select: 0 = ID, 1 = timestamp
//   avm_read          master -> slave  read request
//   avm_waitrequest   slave -> master  stall; request accepted when low
//   avm_readdatavalid slave -> master  read data valid
//   avm_readdata      slave -> master  32-bit read data
// ----------------------------------------------------------------------------
interface sysid_check_ctrl_if;
  logic        avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic        avm_readdatavalid;
  logic [31:0] avm_readdata;

  modport master (
    output avm_address,
    output avm_read,
    input  avm_waitrequest,
    input  avm_readdatavalid,
    input  avm_readdata
  );

  modport slave (
    input  avm_address,
    input  avm_read,
    output avm_waitrequest,
    output avm_readdatavalid,
    output avm_readdata
  );
endinterface

// File: rtl/sysid_check_ctrl.sv
// ----------------------------------------------------------------------------
// sysid_check_ctrl
// Reads the system ID word (address 0) and the build timestamp word
// (address 1) from a sysid peripheral over Avalon-MM, compares them against
// the expected values and reports the outcome. Each read is guarded by a
// cycle timeout with a bounded number of retries.
// Ports:
//   clock, reset   single rising-edge clock, synchronous active-high reset
//   start          one-cycle pulse requesting a (re)check; ignored while busy
//   avm            Avalon-MM master side (sysid_check_ctrl_if.master)
//   busy           check in progress
//   done           check finished; held until next start or reset
//   id_ok, ts_ok   captured words match EXPECTED_ID / EXPECTED_TS
//   timeout_err    a read ran out of retries
//   id_value       last captured ID word
//   ts_value       last captured timestamp word
//   retry_count    retries used by the current/last check, saturating at 15
// All status outputs and bus request signals are registered.
// ----------------------------------------------------------------------------
module sysid_check_ctrl #(
  parameter logic [31:0] EXPECTED_ID    = 32'd0,
  parameter logic [31:0] EXPECTED_TS    = 32'd1368116942,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned MAX_RETRIES    = 3,
  parameter bit          AUTO_START     = 1'b1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  sysid_check_ctrl_if.master  avm,
  output logic                busy,
  output logic                done,
  output logic                id_ok,
  output logic                ts_ok,
  output logic                timeout_err,
  output logic [31:0]         id_value,
  output logic [31:0]         ts_value,
  output logic [3:0]          retry_count
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] ID_REQ  = 3'd1;
  localparam logic [2:0] ID_WAIT = 3'd2;
  localparam logic [2:0] TS_REQ  = 3'd3;
  localparam logic [2:0] TS_WAIT = 3'd4;
  localparam logic [2:0] CHECK   = 3'd5;
  localparam logic [2:0] DONE    = 3'd6;

  // The counter holds the number of cycles already spent, so the last
  // permitted cycle of an attempt is the one where it equals TIMEOUT-1.
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]  MAX_RET  = 4'(MAX_RETRIES);

  logic [2:0]  state_r;
  logic [2:0]  next_s;
  logic [15:0] tmo_cnt_r;
  logic [3:0]  retry_used_r;
  logic        auto_pend_r;
  logic        avm_read_r;
  logic        avm_address_r;

  logic        in_req_s;
  logic        in_wait_s;
  logic        in_id_s;
  logic        accept_s;
  logic        data_s;
  logic        tmo_s;
  logic        retry_s;
  logic        abort_s;
  logic        req_entry_s;
  logic        new_check_s;

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign avm.avm_read    = avm_read_r;
  assign avm.avm_address = avm_address_r;

  // Decode the bus events of the current cycle.
  always_comb begin
    in_req_s  = (state_r == ID_REQ)  || (state_r == TS_REQ);
    in_wait_s = (state_r == ID_WAIT) || (state_r == TS_WAIT);
    in_id_s   = (state_r == ID_REQ)  || (state_r == ID_WAIT);
    accept_s  = in_req_s && !avm.avm_waitrequest;
    // Data only counts with an acceptance or while waiting for a response.
    data_s    = avm.avm_readdatavalid && (accept_s || in_wait_s);
    // Progress (acceptance or data) always wins over an expiring timer.
    tmo_s     = (in_req_s || in_wait_s) && !data_s && !accept_s &&
                (tmo_cnt_r >= TMO_LAST);
    retry_s   = tmo_s && (retry_used_r < MAX_RET);
    abort_s   = tmo_s && !retry_s;
  end

  // Next-state selection and entry events.
  always_comb begin
    next_s = state_r;
    case (state_r)
      IDLE: begin
        if (start || auto_pend_r) next_s = ID_REQ;
        else                      next_s = IDLE;
      end
      ID_REQ, ID_WAIT: begin
        if      (data_s)   next_s = TS_REQ;
        else if (accept_s) next_s = ID_WAIT;
        else if (retry_s)  next_s = ID_REQ;
        else if (abort_s)  next_s = DONE;
        else               next_s = state_r;
      end
      TS_REQ, TS_WAIT: begin
        if      (data_s)   next_s = CHECK;
        else if (accept_s) next_s = TS_WAIT;
        else if (retry_s)  next_s = TS_REQ;
        else if (abort_s)  next_s = DONE;
        else               next_s = state_r;
      end
      CHECK: next_s = DONE;
      DONE: begin
        if (start) next_s = ID_REQ;
        else       next_s = DONE;
      end
      default: next_s = IDLE;
    endcase
    // A retry re-enters the REQ state it is already in.
    req_entry_s = ((next_s == ID_REQ) || (next_s == TS_REQ)) &&
                  ((next_s != state_r) || retry_s);
    new_check_s = ((state_r == IDLE) || (state_r == DONE)) && (next_s == ID_REQ);
  end

  // State, timers, captured data and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r       <= IDLE;
      auto_pend_r   <= AUTO_START;
      tmo_cnt_r     <= 16'd0;
      retry_used_r  <= 4'd0;
      avm_read_r    <= 1'b0;
      avm_address_r <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      id_ok         <= 1'b0;
      ts_ok         <= 1'b0;
      timeout_err   <= 1'b0;
      id_value      <= 32'd0;
      ts_value      <= 32'd0;
      retry_count   <= 4'd0;
    end else begin
      state_r       <= next_s;
      // Auto-start only applies to the first cycle out of reset.
      auto_pend_r   <= 1'b0;
      avm_read_r    <= (next_s == ID_REQ) || (next_s == TS_REQ);
      avm_address_r <= (next_s == TS_REQ);
      busy          <= (next_s == ID_REQ) || (next_s == ID_WAIT) ||
                       (next_s == TS_REQ) || (next_s == TS_WAIT) ||
                       (next_s == CHECK);
      done          <= (next_s == DONE);

      if (req_entry_s)              tmo_cnt_r <= 16'd0;
      else if (in_req_s || in_wait_s) tmo_cnt_r <= sat_inc16(tmo_cnt_r);
      else                          tmo_cnt_r <= tmo_cnt_r;

      // Per-read retry budget restarts for every new read, not for a retry.
      if (req_entry_s && !retry_s) retry_used_r <= 4'd0;
      else if (retry_s)            retry_used_r <= sat_inc4(retry_used_r);
      else                         retry_used_r <= retry_used_r;

      if (new_check_s) begin
        id_ok       <= 1'b0;
        ts_ok       <= 1'b0;
        timeout_err <= 1'b0;
        retry_count <= 4'd0;
      end else begin
        if (retry_s)            retry_count <= sat_inc4(retry_count);
        else                    retry_count <= retry_count;
        if (abort_s)            timeout_err <= 1'b1;
        else                    timeout_err <= timeout_err;
        if (state_r == CHECK) begin
          id_ok <= (id_value == EXPECTED_ID);
          ts_ok <= (ts_value == EXPECTED_TS);
        end else begin
          id_ok <= id_ok;
          ts_ok <= ts_ok;
        end
      end

      if (data_s && in_id_s)       id_value <= avm.avm_readdata;
      else                         id_value <= id_value;
      if (data_s && !in_id_s)      ts_value <= avm.avm_readdata;
      else                         ts_value <= ts_value;
    end
  end

endmodule

// File: tb/tb_sysid_check_ctrl.sv
// ----------------------------------------------------------------------------
// tb_sysid_check_ctrl
// Directed bench for sysid_check_ctrl. "dut" uses default parameters and a
// configurable behavioural slave (stall cycles, response latency, data words,
// injected stray readdatavalid). "dut_t" uses TIMEOUT_CYCLES=8/MAX_RETRIES=2
// against a slave that never answers timestamp reads.
// ----------------------------------------------------------------------------
module tb_sysid_check_ctrl;
  logic clock = 1'b0;
  logic reset;
  logic rst_t;
  logic start;

  always #5 clock = ~clock;

  sysid_check_ctrl_if bus ();
  sysid_check_ctrl_if bus_t ();

  logic        busy, done, id_ok, ts_ok, timeout_err;
  logic [31:0] id_value, ts_value;
  logic [3:0]  retry_count;
  logic        busy_t, done_t, id_ok_t, ts_ok_t, timeout_err_t;
  logic [31:0] id_value_t, ts_value_t;
  logic [3:0]  retry_count_t;

  sysid_check_ctrl dut (
    .clock(clock), .reset(reset), .start(start), .avm(bus),
    .busy(busy), .done(done), .id_ok(id_ok), .ts_ok(ts_ok),
    .timeout_err(timeout_err), .id_value(id_value), .ts_value(ts_value),
    .retry_count(retry_count)
  );

  sysid_check_ctrl #(.TIMEOUT_CYCLES(8), .MAX_RETRIES(2)) dut_t (
    .clock(clock), .reset(rst_t), .start(1'b0), .avm(bus_t),
    .busy(busy_t), .done(done_t), .id_ok(id_ok_t), .ts_ok(ts_ok_t),
    .timeout_err(timeout_err_t), .id_value(id_value_t), .ts_value(ts_value_t),
    .retry_count(retry_count_t)
  );

  // slave configuration, driven by the stimulus process
  int          cfg_wait   = 0;
  int          cfg_lat    = 0;
  logic [31:0] id_word    = 32'd0;
  logic [31:0] ts_word    = 32'd1368116942;
  logic        force_rdv  = 1'b0;
  logic [31:0] force_data = 32'd0;

  // slave state
  int   ws_cnt    = 0;
  int   pend      = 0;
  logic pend_addr = 1'b0;
  logic s_accept;
  int   id_acc    = 0;
  int   ts_acc_t  = 0;
  int   stab_err  = 0;
  logic stall_prev = 1'b0;
  logic addr_prev  = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  // behavioural slave for dut: stall, then same-cycle or delayed data
  always_comb begin
    bus.avm_waitrequest   = bus.avm_read && (ws_cnt < cfg_wait);
    s_accept              = bus.avm_read && !bus.avm_waitrequest;
    bus.avm_readdatavalid = 1'b0;
    bus.avm_readdata      = 32'd0;
    if (force_rdv) begin
      bus.avm_readdatavalid = 1'b1;
      bus.avm_readdata      = force_data;
    end else if (pend == 1) begin
      bus.avm_readdatavalid = 1'b1;
      bus.avm_readdata      = pend_addr ? ts_word : id_word;
    end else if (s_accept && cfg_lat == 0) begin
      bus.avm_readdatavalid = 1'b1;
      bus.avm_readdata      = bus.avm_address ? ts_word : id_word;
    end else begin
      bus.avm_readdatavalid = 1'b0;
    end
  end

  // slave sequencing: stall counter, pending response, ID accept count
  always @(posedge clock) begin
    if (pend > 0) pend <= pend - 1;
    if (s_accept) begin
      ws_cnt <= 0;
      if (!bus.avm_address) id_acc <= id_acc + 1;
      if (cfg_lat > 0) begin
        pend      <= cfg_lat;
        pend_addr <= bus.avm_address;
      end
    end else if (bus.avm_read && bus.avm_waitrequest) begin
      ws_cnt <= ws_cnt + 1;
    end
    if (reset) ws_cnt <= 0;
  end

  // slave for dut_t: ID answered immediately, timestamp never answered
  always_comb begin
    bus_t.avm_waitrequest   = 1'b0;
    bus_t.avm_readdatavalid = bus_t.avm_read && !bus_t.avm_address;
    bus_t.avm_readdata      = 32'd0;
  end

  // count accepted timestamp requests of dut_t (one per TS_REQ entry)
  always @(posedge clock) begin
    if (rst_t) ts_acc_t <= 0;
    else if (bus_t.avm_read && bus_t.avm_address) ts_acc_t <= ts_acc_t + 1;
  end

  // request must not change while stalled
  always @(negedge clock) begin
    if (!reset && stall_prev && (bus.avm_read !== 1'b1 || bus.avm_address !== addr_prev))
      stab_err <= stab_err + 1;
    stall_prev <= bus.avm_read && bus.avm_waitrequest;
    addr_prev  <= bus.avm_address;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check_eq($sformatf("%s_read", tag),  32'(bus.avm_read), 32'd0);
    check_eq($sformatf("%s_busy", tag),  32'(busy), 32'd0);
    check_eq($sformatf("%s_done", tag),  32'(done), 32'd0);
    check_eq($sformatf("%s_idok", tag),  32'(id_ok), 32'd0);
    check_eq($sformatf("%s_tsok", tag),  32'(ts_ok), 32'd0);
    check_eq($sformatf("%s_tmo", tag),   32'(timeout_err), 32'd0);
    check_eq($sformatf("%s_idval", tag), id_value, 32'd0);
    check_eq($sformatf("%s_tsval", tag), ts_value, 32'd0);
    check_eq($sformatf("%s_retry", tag), 32'(retry_count), 32'd0);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (done !== 1'b1 && n < 300) begin
      @(negedge clock);
      n++;
    end
    check_eq($sformatf("%s_done", tag), 32'(done), 32'd1);
  endtask

  task automatic pulse_start();
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int snap;
    reset = 1'b1;
    rst_t = 1'b1;
    start = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_idle("reset");
    reset = 1'b0;
    rst_t = 1'b0;

    // zero-wait slave, default parameters, auto start
    @(negedge clock);  // after edge 1: ID_REQ
    check_eq("e1_read", 32'(bus.avm_read), 32'd1);
    check_eq("e1_addr", 32'(bus.avm_address), 32'd0);
    check_eq("e1_busy", 32'(busy), 32'd1);
    @(negedge clock);  // after edge 2: TS_REQ
    check_eq("e2_read", 32'(bus.avm_read), 32'd1);
    check_eq("e2_addr", 32'(bus.avm_address), 32'd1);
    @(negedge clock);  // after edge 3: CHECK
    check_eq("e3_read", 32'(bus.avm_read), 32'd0);
    check_eq("e3_busy", 32'(busy), 32'd1);
    check_eq("e3_done", 32'(done), 32'd0);
    @(negedge clock);  // after edge 4: DONE
    check_eq("e4_done",  32'(done), 32'd1);
    check_eq("e4_idok",  32'(id_ok), 32'd1);
    check_eq("e4_tsok",  32'(ts_ok), 32'd1);
    check_eq("e4_busy",  32'(busy), 32'd0);
    check_eq("e4_retry", 32'(retry_count), 32'd0);
    check_eq("e4_idval", id_value, 32'd0);
    check_eq("e4_tsval", ts_value, 32'd1368116942);

    // timestamp never returned: 3 TS_REQ entries, then abort
    repeat (60) @(negedge clock);
    check_eq("tmo_entries", 32'(ts_acc_t), 32'd3);
    check_eq("tmo_retry",   32'(retry_count_t), 32'd2);
    check_eq("tmo_err",     32'(timeout_err_t), 32'd1);
    check_eq("tmo_tsok",    32'(ts_ok_t), 32'd0);
    check_eq("tmo_idok",    32'(id_ok_t), 32'd0);
    check_eq("tmo_done",    32'(done_t), 32'd1);
    check_eq("tmo_busy",    32'(busy_t), 32'd0);

    // wrong ID word; extra start while busy must be ignored
    id_word = 32'h12345678;
    cfg_lat = 3;
    snap = id_acc;
    pulse_start();
    check_eq("rs_busy", 32'(busy), 32'd1);
    check_eq("rs_done", 32'(done), 32'd0);
    check_eq("rs_tsok", 32'(ts_ok), 32'd0);
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wait_done("badid");
    check_eq("badid_idok",  32'(id_ok), 32'd0);
    check_eq("badid_tsok",  32'(ts_ok), 32'd1);
    check_eq("badid_idval", id_value, 32'h12345678);
    repeat (5) @(negedge clock);
    check_eq("busy_start_ignored", 32'(id_acc - snap), 32'd1);
    check_eq("badid_hold_done", 32'(done), 32'd1);

    // 5 stall cycles, data 3 cycles after acceptance
    id_word  = 32'd0;
    cfg_wait = 5;
    cfg_lat  = 3;
    pulse_start();
    check_eq("stall_flags_clr", 32'(done), 32'd0);
    wait_done("stall");
    check_eq("stall_idok",  32'(id_ok), 32'd1);
    check_eq("stall_tsok",  32'(ts_ok), 32'd1);
    check_eq("stall_tmo",   32'(timeout_err), 32'd0);
    check_eq("stall_retry", 32'(retry_count), 32'd0);
    check_eq("stall_idval", id_value, 32'd0);
    check_eq("stall_stable", 32'(stab_err), 32'd0);

    // reset during TS_WAIT, late data must be ignored
    cfg_wait = 0;
    cfg_lat  = 3;
    ts_word  = 32'hCAFEF00D;
    pulse_start();
    n = 0;
    while (!(pend > 0 && pend_addr) && n < 100) begin
      @(posedge clock);
      #1;
      n++;
    end
    check_eq("rst_reach_tswait", 32'(n < 100), 32'd1);
    reset = 1'b1;
    repeat (4) @(negedge clock);
    check_idle("rst_mid");
    ts_word    = 32'd1368116942;
    cfg_wait   = 2;
    cfg_lat    = 0;
    force_rdv  = 1'b1;
    force_data = 32'hDEADBEEF;
    reset      = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    force_rdv = 1'b0;
    wait_done("rst_rerun");
    check_eq("rst_idok",  32'(id_ok), 32'd1);
    check_eq("rst_tsok",  32'(ts_ok), 32'd1);
    check_eq("rst_idval", id_value, 32'd0);
    check_eq("rst_tsval", ts_value, 32'd1368116942);
    check_eq("final_stable", 32'(stab_err), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/sysid_check_ctrl.md
SYSID_CHECK_CTRL -- requirements
Module: sysid_check_ctrl

Interface
REQ-001 Parameter EXPECTED_ID, default 0: required system ID word at sysid address 0.
REQ-002 Parameter EXPECTED_TS, default 1368116942: required timestamp word at sysid address 1.
REQ-003 Parameter TIMEOUT_CYCLES, default 255, range 1..65535: cycle limit per read transaction.
REQ-004 Parameter MAX_RETRIES, default 3, range 0..15: retries allowed per read after a timeout.
REQ-005 Parameter AUTO_START, default 1: 1 means a check runs automatically after reset.
REQ-006 clock  in  1  single clock; all logic on rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 start  in  1  one-cycle pulse that requests a (re)check.
REQ-009 avm_address  out  1  sysid word select: 0 = ID, 1 = timestamp.
REQ-010 avm_read  out  1  Avalon-MM read request.
REQ-011 avm_waitrequest  in  1  slave stall; request is accepted on a cycle with avm_read=1 and avm_waitrequest=0.
REQ-012 avm_readdatavalid  in  1  read data valid.
REQ-013 avm_readdata  in  32  read data.
REQ-014 busy  out  1  check in progress.
REQ-015 done  out  1  check finished; held high until the next start or reset.
REQ-016 id_ok  out  1  captured ID equals EXPECTED_ID.
REQ-017 ts_ok  out  1  captured timestamp equals EXPECTED_TS.
REQ-018 timeout_err  out  1  a read exhausted its retries.
REQ-019 id_value  out  32  last captured ID word.
REQ-020 ts_value  out  32  last captured timestamp word.
REQ-021 retry_count  out  4  total retries used in the current or last check, saturating at 15.

Function
REQ-022 The FSM SHALL have the states IDLE, ID_REQ, ID_WAIT, TS_REQ, TS_WAIT, CHECK and DONE.
REQ-023 IDLE SHALL go to ID_REQ on start=1, or on the first cycle after reset when AUTO_START=1.
REQ-024 In ID_REQ and TS_REQ, avm_read=1 with avm_address set to 0 or 1 respectively; in all other states avm_read=0 and avm_address=0.
REQ-025 avm_address and avm_read SHALL stay stable while avm_waitrequest=1.
REQ-026 REQ state transitions on acceptance:
- avm_readdatavalid=1 in the same cycle: capture the data and go to the next REQ state, or to CHECK after the timestamp read.
- otherwise: go to the matching WAIT state.
REQ-027 WAIT state on avm_readdatavalid=1: capture avm_readdata into id_value or ts_value and go to TS_REQ or CHECK.
REQ-028 avm_readdatavalid SHALL be ignored in IDLE, CHECK and DONE, and in a REQ state in any cycle without acceptance.
REQ-029 A 16-bit timeout counter SHALL clear on entry to each REQ state and increment every cycle spent in REQ/WAIT.
REQ-030 When the timeout counter reaches TIMEOUT_CYCLES without data:
- if fewer than MAX_RETRIES retries have been used for this read: increment retry_count and re-enter the same REQ state;
- otherwise: set timeout_err=1 and go to DONE.
REQ-031 CHECK SHALL last one cycle: set id_ok = (id_value == EXPECTED_ID) and ts_ok = (ts_value == EXPECTED_TS), then go to DONE.
REQ-032 In DONE, done=1; start=1 SHALL clear done, id_ok, ts_ok, timeout_err and retry_count, then go to ID_REQ.
REQ-033 busy SHALL be 1 in ID_REQ, ID_WAIT, TS_REQ, TS_WAIT and CHECK, and 0 otherwise.
REQ-034 start SHALL be ignored while busy=1.
REQ-035 On a timeout abort, id_ok and ts_ok SHALL remain 0.
REQ-036 id_value and ts_value SHALL retain prior values until overwritten.

Reset
REQ-037 reset=1 SHALL force IDLE on the next edge and clear every output (avm_read, busy, done, flags, id_value, ts_value, retry_count) to 0.
REQ-038 reset SHALL take priority over start and over an in-flight transaction.
REQ-039 Data returned after a reset that landed mid-read SHALL be ignored per REQ-028.

Verification
REQ-040 Zero-wait slave (address 0 -> 0, address 1 -> 1368116942, readdatavalid in the acceptance cycle), defaults -> avm_read high on edges 1-2 after reset release; done=1, id_ok=1, ts_ok=1, busy=0 from edge 4; retry_count=0.
REQ-041 Slave returns 0x12345678 at address 0 -> done=1, id_ok=0, ts_ok=1, id_value=0x12345678.
REQ-042 TIMEOUT_CYCLES=8, MAX_RETRIES=2, slave never returns timestamp data -> exactly 3 TS_REQ entries, retry_count=2, timeout_err=1, ts_ok=0, done=1.
REQ-043 waitrequest high for 5 cycles, then data 3 cycles after acceptance -> address and read held stable throughout; correct capture; no timeout.
REQ-044 reset asserted during TS_WAIT, late readdatavalid arriving afterwards -> all outputs 0, late data ignored; with AUTO_START=1 a fresh check completes with id_ok=1 and ts_ok=1.
REQ-045 start pulsed while busy, then again in DONE -> first pulse ignored; second pulse clears flags and reruns the check.
